// File: rtl/de_stage_pkg.sv
// Shared decode/execute definitions: control-bundle type, load-flag position
// and the per-edge action encoding used by the D->E pipeline register.
package de_stage_pkg;

   localparam int CTRLW_DEF       = 8;
   localparam int MEMREAD_BIT_DEF = 0;

   typedef logic [CTRLW_DEF-1:0] ctrl_t;

   typedef enum logic [1:0] {
      ACT_LOAD   = 2'd0,
      ACT_HOLD   = 2'd1,
      ACT_BUBBLE = 2'd2
   } act_e;

endpackage

// File: rtl/flopenrc.sv
// Parametrised flop with synchronous reset, synchronous clear and enable.
// Priority: reset > clear > enable.
module flopenrc #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             clear,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // storage element
   always_ff @(posedge clk) begin
      if (reset) begin
         q <= {WIDTH{1'b0}};
      end else if (clear) begin
         q <= {WIDTH{1'b0}};
      end else if (en) begin
         q <= d;
      end else begin
         q <= q;
      end
   end

endmodule

// File: rtl/de_stage.sv
// Decode-to-execute pipeline register with load-use hazard detection,
// flush/stall handling and a saturating bubble counter.
module de_stage
   import de_stage_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int REGW        = 5,
   parameter int CTRLW       = CTRLW_DEF,
   parameter int MEMREAD_BIT = MEMREAD_BIT_DEF,
   parameter int CNTW        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             StallE,
   input  logic             FlushE,
   input  logic             ValidD,
   input  logic [CTRLW-1:0] CtrlD,
   input  logic [REGW-1:0]  RsD,
   input  logic [REGW-1:0]  RtD,
   input  logic [REGW-1:0]  RdD,
   input  logic [WIDTH-1:0] ReadData1D,
   input  logic [WIDTH-1:0] ReadData2D,
   input  logic [WIDTH-1:0] SignImmD,
   input  logic [WIDTH-1:0] PCPlus4D,
   output logic             ValidE,
   output logic [CTRLW-1:0] CtrlE,
   output logic [REGW-1:0]  RsE,
   output logic [REGW-1:0]  RtE,
   output logic [REGW-1:0]  RdE,
   output logic [WIDTH-1:0] ReadData1E,
   output logic [WIDTH-1:0] ReadData2E,
   output logic [WIDTH-1:0] SignImmE,
   output logic [WIDTH-1:0] PCPlus4E,
   output logic             LoadUseStallD,
   output logic [CNTW-1:0]  BubbleCount
);

   localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

   function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
      if (v == CNT_MAX) begin
         return v;
      end else begin
         return v + {{(CNTW-1){1'b0}}, 1'b1};
      end
   endfunction

   act_e            act_s;
   logic            en_s;
   logic            clear_s;
   logic            lus_s;
   logic [CNTW-1:0] cnt_r;

   assign lus_s = ValidE & ValidD & CtrlE[MEMREAD_BIT] & (RtE != {REGW{1'b0}})
                & ((RtE == RsD) | (RtE == RtD));
   assign LoadUseStallD = lus_s;
   assign BubbleCount   = cnt_r;

   // per-edge action select: flush > stall > load-use bubble > load
   always_comb begin
      act_s   = ACT_LOAD;
      en_s    = 1'b0;
      clear_s = 1'b0;
      if (FlushE) begin
         act_s = ACT_BUBBLE;
      end else if (StallE) begin
         act_s = ACT_HOLD;
      end else if (lus_s) begin
         act_s = ACT_BUBBLE;
      end else begin
         act_s = ACT_LOAD;
      end
      case (act_s)
         ACT_LOAD:   en_s    = 1'b1;
         ACT_BUBBLE: clear_s = 1'b1;
         ACT_HOLD:   en_s    = 1'b0;
         default:    clear_s = 1'b1;
      endcase
   end

   // bubble counter, stall-only edges leave it alone
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r <= {CNTW{1'b0}};
      end else if (clear_s) begin
         cnt_r <= sat_inc(cnt_r);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   flopenrc #(.WIDTH(1)) u_valid (
      .clk(clk), .reset(reset), .en(en_s), .clear(clear_s), .d(ValidD), .q(ValidE)
   );
   flopenrc #(.WIDTH(CTRLW)) u_ctrl (
      .clk(clk), .reset(reset), .en(en_s), .clear(clear_s), .d(CtrlD), .q(CtrlE)
   );
   flopenrc #(.WIDTH(REGW)) u_rs (
      .clk(clk), .reset(reset), .en(en_s), .clear(clear_s), .d(RsD), .q(RsE)
   );
   flopenrc #(.WIDTH(REGW)) u_rt (
      .clk(clk), .reset(reset), .en(en_s), .clear(clear_s), .d(RtD), .q(RtE)
   );
   flopenrc #(.WIDTH(REGW)) u_rd (
      .clk(clk), .reset(reset), .en(en_s), .clear(clear_s), .d(RdD), .q(RdE)
   );
   flopenrc #(.WIDTH(WIDTH)) u_rd1 (
      .clk(clk), .reset(reset), .en(en_s), .clear(clear_s), .d(ReadData1D), .q(ReadData1E)
   );
   flopenrc #(.WIDTH(WIDTH)) u_rd2 (
      .clk(clk), .reset(reset), .en(en_s), .clear(clear_s), .d(ReadData2D), .q(ReadData2E)
   );
   flopenrc #(.WIDTH(WIDTH)) u_imm (
      .clk(clk), .reset(reset), .en(en_s), .clear(clear_s), .d(SignImmD), .q(SignImmE)
   );
   flopenrc #(.WIDTH(WIDTH)) u_pc4 (
      .clk(clk), .reset(reset), .en(en_s), .clear(clear_s), .d(PCPlus4D), .q(PCPlus4E)
   );

endmodule

// File: tb/tb_de_stage.sv
// Directed self-checking bench for de_stage; a second instance with a 2-bit
// counter exercises bubble-count saturation.
module tb_de_stage;

   logic        clk;
   logic        reset;
   logic        StallE;
   logic        FlushE;
   logic        ValidD;
   logic [7:0]  CtrlD;
   logic [4:0]  RsD, RtD, RdD;
   logic [31:0] ReadData1D, ReadData2D, SignImmD, PCPlus4D;

   logic        ValidE;
   logic [7:0]  CtrlE;
   logic [4:0]  RsE, RtE, RdE;
   logic [31:0] ReadData1E, ReadData2E, SignImmE, PCPlus4E;
   logic        LoadUseStallD;
   logic [15:0] BubbleCount;

   logic        s_ValidE;
   logic [7:0]  s_CtrlE;
   logic [4:0]  s_RsE, s_RtE, s_RdE;
   logic [31:0] s_ReadData1E, s_ReadData2E, s_SignImmE, s_PCPlus4E;
   logic        s_LoadUseStallD;
   logic [1:0]  s_BubbleCount;

   int vectors;
   int miscompares;
   int exp_cnt;

   de_stage dut (
      .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
      .CtrlD(CtrlD), .RsD(RsD), .RtD(RtD), .RdD(RdD),
      .ReadData1D(ReadData1D), .ReadData2D(ReadData2D), .SignImmD(SignImmD), .PCPlus4D(PCPlus4D),
      .ValidE(ValidE), .CtrlE(CtrlE), .RsE(RsE), .RtE(RtE), .RdE(RdE),
      .ReadData1E(ReadData1E), .ReadData2E(ReadData2E), .SignImmE(SignImmE), .PCPlus4E(PCPlus4E),
      .LoadUseStallD(LoadUseStallD), .BubbleCount(BubbleCount)
   );

   de_stage #(.CNTW(2)) dut_sat (
      .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
      .CtrlD(CtrlD), .RsD(RsD), .RtD(RtD), .RdD(RdD),
      .ReadData1D(ReadData1D), .ReadData2D(ReadData2D), .SignImmD(SignImmD), .PCPlus4D(PCPlus4D),
      .ValidE(s_ValidE), .CtrlE(s_CtrlE), .RsE(s_RsE), .RtE(s_RtE), .RdE(s_RdE),
      .ReadData1E(s_ReadData1E), .ReadData2E(s_ReadData2E), .SignImmE(s_SignImmE),
      .PCPlus4E(s_PCPlus4E), .LoadUseStallD(s_LoadUseStallD), .BubbleCount(s_BubbleCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_d();
      ValidD = 1'b0; CtrlD = 8'h00; RsD = 5'd0; RtD = 5'd0; RdD = 5'd0;
      ReadData1D = 32'h0; ReadData2D = 32'h0; SignImmD = 32'h0; PCPlus4D = 32'h0;
   endtask

   task automatic test_reset();
      ValidD = 1'b1; CtrlD = 8'hFF; RsD = 5'h1F; RtD = 5'h1F; RdD = 5'h1F;
      ReadData1D = 32'hFFFF_FFFF; ReadData2D = 32'hFFFF_FFFF;
      SignImmD = 32'hFFFF_FFFF; PCPlus4D = 32'hFFFF_FFFF;
      StallE = 1'b1; FlushE = 1'b1; reset = 1'b1;
      tick(); tick();
      vectors++;
      if ({ValidE, CtrlE, RsE, RtE, RdE, ReadData1E, ReadData2E, SignImmE, PCPlus4E} !== 152'd0) begin
         miscompares++;
         $display("FAIL reset_fields: got %h expected 0",
                  {ValidE, CtrlE, RsE, RtE, RdE, ReadData1E, ReadData2E, SignImmE, PCPlus4E});
      end
      vectors++;
      if (BubbleCount !== 16'd0) begin
         miscompares++; $display("FAIL reset_count: got %0d expected 0", BubbleCount);
      end
      vectors++;
      if (LoadUseStallD !== 1'b0) begin
         miscompares++; $display("FAIL reset_lus: got %b expected 0", LoadUseStallD);
      end
      clear_d(); StallE = 1'b0; FlushE = 1'b0; reset = 1'b0;
      tick();
      exp_cnt = 0;
      vectors++;
      if (ValidE !== 1'b0 || LoadUseStallD !== 1'b0) begin
         miscompares++; $display("FAIL post_reset_idle: got v=%b lus=%b expected 0 0", ValidE, LoadUseStallD);
      end
   endtask

   task automatic test_load();
      ValidD = 1'b1; CtrlD = 8'h02; RsD = 5'd3; RtD = 5'd4; RdD = 5'd5;
      ReadData1D = 32'h1111_2222; ReadData2D = 32'h3333_4444;
      SignImmD = 32'h10; PCPlus4D = 32'h104;
      tick();
      vectors++;
      if (PCPlus4E !== 32'h104 || SignImmE !== 32'h10 || ValidE !== 1'b1) begin
         miscompares++;
         $display("FAIL load_basic: got pc4=%h imm=%h v=%b expected 104 10 1", PCPlus4E, SignImmE, ValidE);
      end
      vectors++;
      if ({CtrlE, RsE, RtE, RdE, ReadData1E, ReadData2E} !== {8'h02, 5'd3, 5'd4, 5'd5, 32'h1111_2222, 32'h3333_4444}) begin
         miscompares++;
         $display("FAIL load_fields: got %h/%0d/%0d/%0d/%h/%h expected 02/3/4/5/11112222/33334444",
                  CtrlE, RsE, RtE, RdE, ReadData1E, ReadData2E);
      end
      ValidD = 1'b0; PCPlus4D = 32'h108;
      tick();
      vectors++;
      if (ValidE !== 1'b0 || PCPlus4E !== 32'h108 || BubbleCount !== exp_cnt[15:0]) begin
         miscompares++;
         $display("FAIL invalid_load: got v=%b pc4=%h cnt=%0d expected 0 108 %0d", ValidE, PCPlus4E, BubbleCount, exp_cnt);
      end
   endtask

   task automatic test_load_use();
      clear_d();
      ValidD = 1'b1; CtrlD = 8'h01; RsD = 5'd1; RtD = 5'd8; PCPlus4D = 32'h1F0;
      tick();
      ValidD = 1'b1; CtrlD = 8'h00; RsD = 5'd8; RtD = 5'd3; RdD = 5'd2; PCPlus4D = 32'h200;
      #1;
      vectors++;
      if (LoadUseStallD !== 1'b1) begin
         miscompares++; $display("FAIL lus_rs_match: got %b expected 1", LoadUseStallD);
      end
      tick();
      exp_cnt++;
      vectors++;
      if (ValidE !== 1'b0 || CtrlE !== 8'h00 || RtE !== 5'd0 || PCPlus4E !== 32'h0 || BubbleCount !== exp_cnt[15:0]) begin
         miscompares++;
         $display("FAIL lus_bubble: got v=%b ctrl=%h rt=%0d pc4=%h cnt=%0d expected 0 00 0 0 %0d",
                  ValidE, CtrlE, RtE, PCPlus4E, BubbleCount, exp_cnt);
      end
      vectors++;
      if (LoadUseStallD !== 1'b0) begin
         miscompares++; $display("FAIL lus_after_bubble: got %b expected 0", LoadUseStallD);
      end
      tick();
      vectors++;
      if (ValidE !== 1'b1 || RsE !== 5'd8 || PCPlus4E !== 32'h200 || BubbleCount !== exp_cnt[15:0]) begin
         miscompares++;
         $display("FAIL lus_reissue: got v=%b rs=%0d pc4=%h cnt=%0d expected 1 8 200 %0d",
                  ValidE, RsE, PCPlus4E, BubbleCount, exp_cnt);
      end
      // Rt-side match, then gated off by an invalid D slot
      CtrlD = 8'h01; RsD = 5'd0; RtD = 5'd5;
      tick();
      CtrlD = 8'h00; RsD = 5'd7; RtD = 5'd5;
      #1;
      vectors++;
      if (LoadUseStallD !== 1'b1) begin
         miscompares++; $display("FAIL lus_rt_match: got %b expected 1", LoadUseStallD);
      end
      ValidD = 1'b0;
      #1;
      vectors++;
      if (LoadUseStallD !== 1'b0) begin
         miscompares++; $display("FAIL lus_invalid_d: got %b expected 0", LoadUseStallD);
      end
      tick();
      vectors++;
      if (ValidE !== 1'b0 || RsE !== 5'd7 || BubbleCount !== exp_cnt[15:0]) begin
         miscompares++;
         $display("FAIL invalid_no_bubble: got v=%b rs=%0d cnt=%0d expected 0 7 %0d", ValidE, RsE, BubbleCount, exp_cnt);
      end
   endtask

   task automatic test_rt_zero();
      clear_d();
      ValidD = 1'b1; CtrlD = 8'h01;
      tick();
      CtrlD = 8'h00; PCPlus4D = 32'h240;
      #1;
      vectors++;
      if (LoadUseStallD !== 1'b0) begin
         miscompares++; $display("FAIL rt_zero_lus: got %b expected 0", LoadUseStallD);
      end
      tick();
      vectors++;
      if (ValidE !== 1'b1 || PCPlus4E !== 32'h240 || BubbleCount !== exp_cnt[15:0]) begin
         miscompares++;
         $display("FAIL rt_zero_load: got v=%b pc4=%h cnt=%0d expected 1 240 %0d", ValidE, PCPlus4E, BubbleCount, exp_cnt);
      end
   endtask

   task automatic test_stall_flush();
      clear_d();
      ValidD = 1'b1; CtrlD = 8'h04; RsD = 5'd2; RtD = 5'd3; RdD = 5'd4;
      ReadData1D = 32'hAAAA; SignImmD = 32'h20; PCPlus4D = 32'h300;
      tick();
      StallE = 1'b1;
      for (int i = 0; i < 3; i++) begin
         PCPlus4D = 32'h400 + 32'(i); RsD = 5'(10 + i); ValidD = i[0]; ReadData1D = 32'h5555_0000 + 32'(i);
         tick();
         vectors++;
         if (ValidE !== 1'b1 || PCPlus4E !== 32'h300 || RsE !== 5'd2 || ReadData1E !== 32'hAAAA
             || BubbleCount !== exp_cnt[15:0]) begin
            miscompares++;
            $display("FAIL stall_hold[%0d]: got v=%b pc4=%h rs=%0d rd1=%h cnt=%0d expected 1 300 2 aaaa %0d",
                     i, ValidE, PCPlus4E, RsE, ReadData1E, BubbleCount, exp_cnt);
         end
      end
      FlushE = 1'b1;
      tick();
      exp_cnt++;
      vectors++;
      if (ValidE !== 1'b0 || PCPlus4E !== 32'h0 || ReadData1E !== 32'h0 || BubbleCount !== exp_cnt[15:0]) begin
         miscompares++;
         $display("FAIL flush_over_stall: got v=%b pc4=%h rd1=%h cnt=%0d expected 0 0 0 %0d",
                  ValidE, PCPlus4E, ReadData1E, BubbleCount, exp_cnt);
      end
      // stall while a load-use hazard is pending: hold, no bubble counted
      FlushE = 1'b0; StallE = 1'b0;
      clear_d(); ValidD = 1'b1; CtrlD = 8'h01; RtD = 5'd6; PCPlus4D = 32'h320;
      tick();
      CtrlD = 8'h00; RsD = 5'd6; RtD = 5'd1; PCPlus4D = 32'h324; StallE = 1'b1;
      tick();
      vectors++;
      if (CtrlE !== 8'h01 || PCPlus4E !== 32'h320 || BubbleCount !== exp_cnt[15:0] || LoadUseStallD !== 1'b1) begin
         miscompares++;
         $display("FAIL stall_over_lus: got ctrl=%h pc4=%h cnt=%0d lus=%b expected 01 320 %0d 1",
                  CtrlE, PCPlus4E, BubbleCount, LoadUseStallD, exp_cnt);
      end
      StallE = 1'b0;
      tick();
      exp_cnt++;
      vectors++;
      if (ValidE !== 1'b0 || BubbleCount !== exp_cnt[15:0]) begin
         miscompares++;
         $display("FAIL lus_after_stall: got v=%b cnt=%0d expected 0 %0d", ValidE, BubbleCount, exp_cnt);
      end
   endtask

   task automatic test_saturation();
      clear_d(); reset = 1'b1;
      tick();
      reset = 1'b0; FlushE = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         tick();
         vectors++;
         if (s_BubbleCount !== ((i < 3) ? 2'(i) : 2'd3)) begin
            miscompares++;
            $display("FAIL sat_count[%0d]: got %0d expected %0d", i, s_BubbleCount, (i < 3) ? i : 3);
         end
      end
      FlushE = 1'b0;
      vectors++;
      if (BubbleCount !== 16'd5) begin
         miscompares++; $display("FAIL wide_count: got %0d expected 5", BubbleCount);
      end
      // reset arriving mid-stall with a hazard pending
      ValidD = 1'b1; CtrlD = 8'h01; RtD = 5'd9; PCPlus4D = 32'h500;
      tick();
      CtrlD = 8'h00; RsD = 5'd9; StallE = 1'b1;
      tick();
      vectors++;
      if (ValidE !== 1'b1 || LoadUseStallD !== 1'b1) begin
         miscompares++; $display("FAIL pre_reset_state: got v=%b lus=%b expected 1 1", ValidE, LoadUseStallD);
      end
      reset = 1'b1;
      tick();
      vectors++;
      if ({ValidE, CtrlE, RsE, RtE, RdE, ReadData1E, ReadData2E, SignImmE, PCPlus4E} !== 152'd0
          || BubbleCount !== 16'd0 || s_BubbleCount !== 2'd0 || LoadUseStallD !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid_stall: got v=%b pc4=%h cnt=%0d scnt=%0d lus=%b expected all 0",
                  ValidE, PCPlus4E, BubbleCount, s_BubbleCount, LoadUseStallD);
      end
      reset = 1'b0; StallE = 1'b0;
   endtask

   initial begin
      vectors = 0; miscompares = 0; exp_cnt = 0;
      reset = 1'b1; StallE = 1'b0; FlushE = 1'b0;
      clear_d();
      test_reset();
      test_load();
      test_load_use();
      test_rt_zero();
      test_stall_flush();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/de_stage.md
DE_STAGE -- requirements
Module: de_stage

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the datapath word width (register operands, immediate, PC+4).
REQ-002 Parameter REGW, default 5, SHALL set the register-specifier width.
REQ-003 Parameter CTRLW, default 8, SHALL set the width of the opaque decode-control bundle.
REQ-004 Parameter MEMREAD_BIT, default 0, SHALL give the CtrlE bit index meaning "instruction in E is a load".
REQ-005 Parameter CNTW, default 16, SHALL set the bubble-counter width.
REQ-006 Ports, one per line (name  direction  width  meaning):
  clk  in  1  single clock, rising edge
  reset  in  1  synchronous, active-high
  StallE  in  1  hold E contents
  FlushE  in  1  replace E contents with a bubble
  ValidD  in  1  D holds a real instruction
  CtrlD  in  CTRLW  decode control bundle
  RsD, RtD, RdD  in  REGW  register specifiers
  ReadData1D, ReadData2D  in  WIDTH  register-file operands
  SignImmD, PCPlus4D  in  WIDTH  immediate, PC+4
  ValidE, CtrlE, RsE, RtE, RdE, ReadData1E, ReadData2E, SignImmE, PCPlus4E  out  as D counterparts  registered E copies
  LoadUseStallD  out  1  combinational load-use hazard; upstream SHALL hold F/D while high
  BubbleCount  out  CNTW  saturating count of inserted bubbles

Function
REQ-007 All E outputs SHALL be registered and update only on the rising edge of clk.
REQ-008 Per-edge priority SHALL be: reset > FlushE > StallE > load-use bubble > normal load.
REQ-009 Normal load SHALL copy every D input to its E output with 1-cycle latency.
REQ-010 A bubble SHALL set ValidE=0 and CtrlE, RsE, RtE, RdE and all WIDTH outputs to 0.
REQ-011 StallE high without FlushE SHALL hold every E output unchanged, including ValidE.
REQ-012 LoadUseStallD SHALL equal ValidE & ValidD & CtrlE[MEMREAD_BIT] & (RtE != 0) & ((RtE == RsD) | (RtE == RtD)).
REQ-013 LoadUseStallD high with FlushE and StallE low SHALL insert a bubble at the edge, not load D.
REQ-014 A load-use bubble SHALL last exactly one cycle: the next edge loads the held D instruction, because the bubble clears ValidE.
REQ-015 BubbleCount SHALL increment by 1 at each edge where a bubble is inserted by FlushE or load-use; StallE-only edges SHALL NOT increment it.
REQ-016 BubbleCount SHALL saturate at 2^CNTW-1 and never wrap.
REQ-017 FlushE and StallE both high SHALL insert a bubble; flush wins.
REQ-018 ValidD=0 on a normal load SHALL propagate ValidE=0 but still copy the data fields; it SHALL NOT count as a bubble.

Reset
REQ-019 reset high at an edge SHALL force ValidE=0, all E fields to 0 and BubbleCount=0, overriding all other inputs, including mid-stall or mid-hazard.
REQ-020 After reset ValidE=0, so LoadUseStallD SHALL be 0 until a valid load reaches E.

Structure
REQ-021 A shared package SHALL hold the control-bundle typedef and the MEMREAD_BIT default so the decoder and de_stage agree.
REQ-022 Each field SHALL use one parametrised sub-module flopenrc (enable, synchronous clear, synchronous reset); hazard and counter logic SHALL sit in de_stage.

Verification
REQ-023 Scenario: reset with all D inputs 0xFFFF_FFFF -> all E outputs 0, BubbleCount 0, LoadUseStallD 0.
REQ-024 Scenario: load ValidD=1, PCPlus4D=0x104, SignImmD=0x10 -> next cycle PCPlus4E=0x104, SignImmE=0x10, ValidE=1.
REQ-025 Scenario: load in E with RtE=8, CtrlE[0]=1, then D instruction with RsD=8 -> LoadUseStallD=1; one bubble (ValidE=0); held instruction enters E the next cycle; BubbleCount=1.
REQ-026 Scenario: RtE=0 load, RsD=0 -> LoadUseStallD=0, no bubble.
REQ-027 Scenario: StallE=1 for 3 cycles with changing D inputs -> E unchanged; FlushE=1 with StallE=1 -> bubble; BubbleCount +1.
REQ-028 Scenario: CNTW=2, five consecutive flushes -> BubbleCount stays at 3; reset mid-stall -> all outputs 0 at the next edge.
